// File: rtl/logic_unit_pkg.sv
// Shared ALU definitions: logic-slice opcodes, also consumed by the ALU decoder.
package logic_unit_pkg;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOT = 2'b11;

endpackage

// File: rtl/logic_bit.sv
// Single-bit logic cell: AND/OR/XOR/NOT(A) selected by a 2-bit opcode.
module logic_bit
    import logic_unit_pkg::*;
(
    input  logic       Ai,
    input  logic       Bi,
    input  logic [1:0] sel,
    output logic       Ei
);

    always_comb begin
        case (sel)
            LOGIC_AND: Ei = Ai & Bi;
            LOGIC_OR:  Ei = Ai | Bi;
            LOGIC_XOR: Ei = Ai ^ Bi;
            LOGIC_NOT: Ei = ~Ai;
            // Unknown opcode propagates X rather than picking an operation.
            default:   Ei = 1'bx;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// Bitwise logic slice of the ALU: combinational result plus a registered copy,
// zero flag and valid strobe for pipelined use.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Ai,
    input  logic [WIDTH-1:0] Bi,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] Ei,
    output logic [WIDTH-1:0] Ei_q,
    output logic             zero_q,
    output logic             valid_q
);

    logic zero_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic_bit u_bit (
            .Ai  (Ai[i]),
            .Bi  (Bi[i]),
            .sel (sel),
            .Ei  (Ei[i])
        );
    end

    assign zero_d = (Ei == {WIDTH{1'b0}});

    // Result and flag hold when en is low; valid is a one-cycle strobe per load.
    always_ff @(posedge clk) begin
        if (rst) begin
            Ei_q    <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            Ei_q    <= Ei;
            zero_q  <= zero_d;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: 1-bit truth table, 32-bit vectors,
// registered-path sequences and randomized traffic against a reference model.
module tb_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1, en32;
    logic [1:0]  sel1, sel32;
    logic [0:0]  a1, b1;
    logic [0:0]  e1, e1_q;
    logic        z1_q, v1_q;
    logic [31:0] a32, b32, e32, e32_q;
    logic        z32_q, v32_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_unit #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .Ai      (a1),
        .Bi      (b1),
        .sel     (sel1),
        .en      (en1),
        .Ei      (e1),
        .Ei_q    (e1_q),
        .zero_q  (z1_q),
        .valid_q (v1_q)
    );

    logic_unit #(.WIDTH(32)) dut32 (
        .clk     (clk),
        .rst     (rst),
        .Ai      (a32),
        .Bi      (b32),
        .sel     (sel32),
        .en      (en32),
        .Ei      (e32),
        .Ei_q    (e32_q),
        .zero_q  (z32_q),
        .valid_q (v32_q)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tab1[16];
    vec_t tab32[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-bit arithmetic truth model, independent of the opcode case structure.
    function automatic logic [31:0] ref_op(input int op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [31:0] res = '0;
        for (int i = 0; i < w; i++) begin
            int x = a[i] ? 1 : 0;
            int y = b[i] ? 1 : 0;
            int r;
            case (op)
                0:       r = x * y;
                1:       r = x + y - x * y;
                2:       r = (x + y) % 2;
                default: r = 1 - x;
            endcase
            res[i] = (r != 0);
        end
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] m_q;
    logic        m_zero, m_valid;
    logic [31:0] m_next;
    logic [31:0] hold_val;

    initial begin
        // 1-bit exhaustive table, index = {sel, a, b}
        logic [15:0] exp_bits;
        exp_bits = 16'b0011_0110_1110_1000;
        for (int i = 0; i < 16; i++) begin
            tab1[i].sel = i[3:2];
            tab1[i].a   = {31'd0, i[1]};
            tab1[i].b   = {31'd0, i[0]};
            tab1[i].exp = {31'd0, exp_bits[i]};
        end
        tab32[0] = '{2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        tab32[1] = '{2'b01, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF};
        tab32[2] = '{2'b10, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB};
        tab32[3] = '{2'b11, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0F0F_EDCB};

        rst = 1'b1; en1 = 1'b0; en32 = 1'b0;
        sel1 = 2'b00; a1 = 1'b0; b1 = 1'b0;
        sel32 = 2'b00; a32 = '0; b32 = '0;
        tick();
        check("reset_ei_q", e32_q, 32'h0);
        check("reset_zero", {31'd0, z32_q}, 32'h0);
        check("reset_valid", {31'd0, v32_q}, 32'h0);
        check("reset_valid_w1", {31'd0, v1_q}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            sel1 = tab1[i].sel; a1 = tab1[i].a[0]; b1 = tab1[i].b[0];
            #1;
            check($sformatf("w1_sel%0d_a%0d_b%0d", sel1, a1, b1), {31'd0, e1}, tab1[i].exp);
        end

        for (int i = 0; i < 4; i++) begin
            sel32 = tab32[i].sel; a32 = tab32[i].a; b32 = tab32[i].b;
            #1;
            check($sformatf("w32_sel%0d", sel32), e32, tab32[i].exp);
        end

        // Reset with en=1: registers clear, combinational result still live.
        @(negedge clk);
        rst = 1'b1; en32 = 1'b1; sel32 = 2'b01; a32 = 32'h1234_0000; b32 = 32'h0000_5678;
        tick();
        check("rst_en_ei_q", e32_q, 32'h0);
        check("rst_en_zero", {31'd0, z32_q}, 32'h0);
        check("rst_en_valid", {31'd0, v32_q}, 32'h0);
        check("rst_en_ei", e32, 32'h1234_5678);
        rst = 1'b0;

        // Load a zero result, then hold with en=0 while inputs change.
        sel32 = 2'b10; a32 = 32'hDEAD_BEEF; b32 = 32'hDEAD_BEEF; en32 = 1'b1;
        tick();
        check("xor_self_ei_q", e32_q, 32'h0);
        check("xor_self_zero", {31'd0, z32_q}, 32'h1);
        check("xor_self_valid", {31'd0, v32_q}, 32'h1);
        sel32 = 2'b01; a32 = 32'h0000_00FF; en32 = 1'b1;
        tick();
        check("load_nz_ei_q", e32_q, 32'hDEAD_BEFF);
        check("load_nz_zero", {31'd0, z32_q}, 32'h0);
        en32 = 1'b0; a32 = 32'h5555_0000;
        tick();
        check("hold_ei_q", e32_q, 32'hDEAD_BEFF);
        check("hold_zero", {31'd0, z32_q}, 32'h0);
        check("hold_valid", {31'd0, v32_q}, 32'h0);
        tick();
        check("hold2_ei_q", e32_q, 32'hDEAD_BEFF);

        // NOT ignores B.
        sel32 = 2'b11; a32 = '0;
        for (int i = 0; i < 8; i++) begin
            b32 = $urandom;
            #1;
            check("not_b_indep", e32, 32'hFFFF_FFFF);
        end

        // Randomized traffic against the reference model, including back-to-back loads.
        rst = 1'b1; tick(); rst = 1'b0;
        m_q = '0; m_zero = 1'b0; m_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            sel32 = 2'($urandom_range(0, 3));
            a32   = $urandom;
            b32   = $urandom;
            if ($urandom_range(0, 3) == 0) b32 = a32;
            en32  = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 19) == 0);
            #1;
            m_next = ref_op(int'(sel32), a32, b32, 32);
            check("rand_ei", e32, m_next);
            if (rst) begin
                m_q = '0; m_zero = 1'b0; m_valid = 1'b0;
            end else if (en32) begin
                m_q = m_next; m_zero = (m_next == 32'h0); m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            tick();
            check("rand_ei_q", e32_q, m_q);
            check("rand_zero", {31'd0, z32_q}, {31'd0, m_zero});
            check("rand_valid", {31'd0, v32_q}, {31'd0, m_valid});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
